instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 redirect_en  input  1  branch or exception redirect request for this cycle.
REQ-005 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and stored as 0.
REQ-006 inst_req  output  1  I-cache request valid.
REQ-007 inst_addr  output  32  request address, {pc[31:3],3'b000}.
REQ-008 inst_addr_ok  input  1  I-cache accepts the request this cycle.
REQ-009 inst_data_ok  input  1  I-cache returns data this cycle.
REQ-010 inst_rdata1 / inst_rdata2  input  32 each  words at inst_addr and inst_addr+4.
REQ-011 fifo_full  input  1  downstream instruction FIFO has fewer than 2 free entries.
REQ-012 fifo_write_en1 / fifo_write_en2  output  1 each  write strobes; en2 only with en1.
REQ-013 fifo_write_data1 / fifo_write_data2  output  32 each  instruction words.
REQ-014 fifo_write_address1 / fifo_write_address2  output  32 each  PCs of those words.
REQ-015 fifo_flush  output  1  clears the downstream FIFO; combinational, equal to redirect_en.

Function
REQ-016 The block SHALL hold a 32-bit pc register and a 3-state FSM {REQ, WAIT, DISCARD}, with at most one outstanding I-cache request.
REQ-017 REQ state: inst_req = !fifo_full && !redirect_en; inst_req && inst_addr_ok -> WAIT; otherwise stay in REQ.
REQ-018 WAIT state: inst_req = 0; inst_data_ok && !redirect_en -> write, then REQ; inst_data_ok && redirect_en -> REQ with no write; !inst_data_ok && redirect_en -> DISCARD.
REQ-019 DISCARD state: inst_req = 0; inst_data_ok -> REQ with all write strobes 0; returned data SHALL be dropped.
REQ-020 Write with pc[2]==0: en1=en2=1; data1=rdata1, addr1=pc; data2=rdata2, addr2=pc+4; pc <= pc+8.
REQ-021 Write with pc[2]==1: en1=1, en2=0; data1=rdata2, addr1=pc; pc <= pc+4; data2/addr2 are don't-care.
REQ-022 Write strobes SHALL be combinational in the inst_data_ok cycle (zero latency) and 0 in every other cycle.
REQ-023 redirect_en in any state SHALL set pc <= {redirect_pc[31:2],2'b00} at the next edge, overriding any increment.
REQ-024 In a redirect cycle all write strobes SHALL be 0 and fifo_flush SHALL be 1.
REQ-025 REQ with redirect_en SHALL stay in REQ, because inst_req is forced to 0 and no handshake can complete.
REQ-026 A redirect in DISCARD SHALL update pc and stay in DISCARD, unless inst_data_ok occurs in the same cycle, in which case the next state is REQ.
REQ-027 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFF8 + 8 wraps to 0.
REQ-028 fifo_full is sampled only at request issue; the FIFO cannot fill between issue and return, so no hold buffer is required.
REQ-029 Minimum throughput: 2 instructions per 2 cycles when addr_ok is immediate and data_ok arrives the following cycle.

Reset
REQ-030 rst SHALL asynchronously force pc=RESET_PC and state=REQ.
REQ-031 While rst=1, inst_req and all write strobes SHALL be 0.
REQ-032 Reset asserted mid-transaction (WAIT or DISCARD) SHALL abandon the transaction; a data_ok arriving after rst deasserts while in REQ SHALL be ignored.
REQ-033 First request after reset SHALL be issued in the first cycle with rst=0, provided fifo_full=0.

Verification
REQ-034 Reset with RESET_PC=BFC0_0000, addr_ok=1, data_ok next cycle, rdata 11111111/22222222 -> en1=en2=1, addr1=BFC0_0000, addr2=BFC0_0004, next inst_addr=BFC0_0008.
REQ-035 redirect_pc=0000_1004 then data_ok with rdata AAAA/BBBB -> only en1, data1=BBBB, addr1=0000_1004, next inst_addr=0000_1008.
REQ-036 Redirect to 0000_2000 while in WAIT, data_ok 3 cycles later -> no write strobe, fifo_flush=1 in the redirect cycle only, next request inst_addr=0000_2000.
REQ-037 fifo_full=1 for 5 cycles in REQ -> inst_req=0 for those 5 cycles; inst_req=1 in the cycle fifo_full falls; pc unchanged.
REQ-038 Redirect coincident with data_ok in WAIT -> no write, state REQ, pc=redirect_pc.
REQ-039 pc=FFFF_FFF8, normal two-word fetch -> addr2=FFFF_FFFC, next inst_addr=0000_0000.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: I-cache request/response and instruction-FIFO write bundle for the fetch stage.
// Rev 1.0
`default_nettype none

interface fetch_if;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata1;
  logic [31:0] inst_rdata2;
  logic        fifo_full;
  logic        fifo_write_en1;
  logic        fifo_write_en2;
  logic [31:0] fifo_write_data1;
  logic [31:0] fifo_write_data2;
  logic [31:0] fifo_write_address1;
  logic [31:0] fifo_write_address2;
  logic        fifo_flush;

  modport master (
    input  redirect_en, redirect_pc, inst_addr_ok, inst_data_ok,
           inst_rdata1, inst_rdata2, fifo_full,
    output inst_req, inst_addr, fifo_write_en1, fifo_write_en2,
           fifo_write_data1, fifo_write_data2,
           fifo_write_address1, fifo_write_address2, fifo_flush
  );

  modport slave (
    output redirect_en, redirect_pc, inst_addr_ok, inst_data_ok,
           inst_rdata1, inst_rdata2, fifo_full,
    input  inst_req, inst_addr, fifo_write_en1, fifo_write_en2,
           fifo_write_data1, fifo_write_data2,
           fifo_write_address1, fifo_write_address2, fifo_flush
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC + single-outstanding I-cache fetch FSM feeding a 2-wide instruction FIFO.
// Rev 1.0
`default_nettype none

module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  wire logic clk,
  input  wire logic rst,
  fetch_if.master   bus
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;

  logic        w_req;
  logic        w_write;
  logic        w_pair;

  // Gating with rst keeps request and strobes quiet for the whole reset pulse.
  always_comb begin
    w_req   = 1'b0;
    w_write = 1'b0;
    w_pair  = 1'b0;
    w_req   = !rst && (r_state == S_REQ) && !bus.fifo_full && !bus.redirect_en;
    w_write = !rst && (r_state == S_WAIT) && bus.inst_data_ok && !bus.redirect_en;
    w_pair  = !r_pc[2];
  end

  assign bus.inst_req            = w_req;
  assign bus.inst_addr           = {r_pc[31:3], 3'b000};
  assign bus.fifo_flush          = bus.redirect_en;
  assign bus.fifo_write_en1      = w_write;
  assign bus.fifo_write_en2      = w_write && w_pair;
  assign bus.fifo_write_data1    = w_pair ? bus.inst_rdata1 : bus.inst_rdata2;
  assign bus.fifo_write_address1 = r_pc;
  assign bus.fifo_write_data2    = bus.inst_rdata2;
  assign bus.fifo_write_address2 = r_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= S_REQ;
    end else begin
      if (bus.redirect_en) begin
        r_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      end else if (w_write) begin
        r_pc <= r_pc + (w_pair ? 32'd8 : 32'd4);
      end

      case (r_state)
        S_REQ: begin
          if (w_req && bus.inst_addr_ok) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.inst_data_ok)     r_state <= S_REQ;
          else if (bus.redirect_en) r_state <= S_DISCARD;
        end
        S_DISCARD: begin
          if (bus.inst_data_ok) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: randomized scoreboard bench against a transaction-level fetch model.
// Rev 1.0
`default_nettype none

module tb_instruction_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        en1;
  } cyc_t;

  typedef struct {
    logic        en2;
    logic [31:0] d1;
    logic [31:0] a1;
    logic [31:0] d2;
    logic [31:0] a2;
  } wr_t;

  logic clk;
  logic rst;
  fetch_if bus ();

  instruction_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];
  int   errs   = 0;
  int   checks = 0;

  // Reference model: program counter, one-outstanding-request flag, and
  // whether that outstanding request was invalidated by a redirect.
  logic [31:0] m_pc    = RST_PC;
  bit          m_busy  = 1'b0;
  bit          m_stale = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rstv, input bit ff, input bit redir, input logic [31:0] rpc,
                       input bit aok, input bit dok, input logic [31:0] rd1, input logic [31:0] rd2);
    cyc_t c;
    wr_t  w;
    bit   req;
    bit   wr;
    @(posedge clk);
    #1;
    rst              = rstv;
    bus.fifo_full    = ff;
    bus.redirect_en  = rstv ? 1'b0 : redir;
    bus.redirect_pc  = rpc;
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata1  = rd1;
    bus.inst_rdata2  = rd2;
    if (rstv) begin
      m_pc    = RST_PC;
      m_busy  = 1'b0;
      m_stale = 1'b0;
      c = '{rst: 1'b1, req: 1'b0, addr: {RST_PC[31:3], 3'b000}, flush: 1'b0, en1: 1'b0};
      cyc_q.push_back(c);
      return;
    end
    req = !m_busy && !ff && !redir;
    wr  = m_busy && dok && !m_stale && !redir;
    c = '{rst: 1'b0, req: req, addr: {m_pc[31:3], 3'b000}, flush: redir, en1: wr};
    cyc_q.push_back(c);
    if (wr) begin
      if (m_pc[2] == 1'b0) w = '{en2: 1'b1, d1: rd1, a1: m_pc, d2: rd2, a2: m_pc + 32'd4};
      else                 w = '{en2: 1'b0, d1: rd2, a1: m_pc, d2: 32'h0, a2: 32'h0};
      wr_q.push_back(w);
      m_pc = m_pc + (m_pc[2] ? 32'd4 : 32'd8);
    end
    if (redir) m_pc = {rpc[31:2], 2'b00};
    if (m_busy) begin
      if (dok)        begin m_busy = 1'b0; m_stale = 1'b0; end
      else if (redir) m_stale = 1'b1;
    end else if (req && aok) begin
      m_busy = 1'b1;
    end
  endtask

  // Monitor: checks every cycle's outputs; pops a write record whenever a write is presented.
  always @(negedge clk) begin
    cyc_t c;
    wr_t  w;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("inst_req",   {31'b0, bus.inst_req},       {31'b0, c.req});
      chk("inst_addr",  bus.inst_addr,               c.addr);
      chk("fifo_flush", {31'b0, bus.fifo_flush},     {31'b0, c.flush});
      chk("write_en1",  {31'b0, bus.fifo_write_en1}, {31'b0, c.en1});
      if (c.rst) chk("en2_in_reset", {31'b0, bus.fifo_write_en2}, 32'h0);
      if (bus.fifo_write_en1 || c.en1) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'h1, 32'h0);
        end else begin
          w = wr_q.pop_front();
          chk("write_en2", {31'b0, bus.fifo_write_en2}, {31'b0, w.en2});
          chk("write_data1", bus.fifo_write_data1, w.d1);
          chk("write_addr1", bus.fifo_write_address1, w.a1);
          if (w.en2) begin
            chk("write_data2", bus.fifo_write_data2, w.d2);
            chk("write_addr2", bus.fifo_write_address2, w.a2);
          end
        end
      end else begin
        chk("write_en2_idle", {31'b0, bus.fifo_write_en2}, 32'h0);
      end
    end
  end

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(4, 0))
      0:       return 32'hFFFF_FFF8;
      1:       return 32'hFFFF_FFFC;
      2:       return 32'h0000_1004;
      3:       return 32'h0000_2000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.fifo_full = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = 32'h0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
    bus.inst_rdata1 = 32'h0; bus.inst_rdata2 = 32'h0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    // Reset fetch pair, then odd-word redirect fetch.
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 32'h1111_1111, 32'h2222_2222);
    cycle(0, 0, 1, 32'h0000_1004, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 32'h0000_AAAA, 32'h0000_BBBB);
    // Redirect while waiting; late data dropped.
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_2000, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    // FIFO full for five cycles.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    // Redirect coincident with data_ok, then wrap-around fetch.
    cycle(0, 0, 1, 32'hFFFF_FFF8, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 32'h3333_3333, 32'h4444_4444);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 32'h5555_5555, 32'h6666_6666);

    for (int i = 0; i < 3000; i++) begin
      bit rs;
      bit dok;
      rs  = ($urandom_range(99, 0) < 1);
      dok = m_busy ? ($urandom_range(99, 0) < 50) : ($urandom_range(99, 0) < 10);
      if (rs) begin
        cycle(1, 0, 0, 0, 0, $urandom_range(1, 0), 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        cycle(0, ($urandom_range(99, 0) < 20), ($urandom_range(99, 0) < 10), pick_pc(),
              ($urandom_range(99, 0) < 60), dok, $urandom, $urandom);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pending_writes", wr_q.size(), 32'h0);
    chk("pending_cycles", cyc_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
